// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking write arbiter feeding one shared FIFO with credit flow control.
// Define FIFO_WR_ARB_STATS_EN to build the saturating arbitration stall counter.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_rd_pop,
    input  logic                          fifo_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   credit,
    output logic                          err_overflow,
    output logic [15:0]                   stall_cnt
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] LAST_IDX_C = IW'(NUM_REQ - 1);
    localparam logic [IW:0]   NUM_REQ_C  = (IW+1)'(NUM_REQ);

    typedef enum logic [0:0] {ARB = 1'b0, LOCK = 1'b1} state_t;

    state_t                  state_r, state_nxt_s;
    logic [IW-1:0]           ptr_r, ptr_nxt_s;
    logic [IW-1:0]           owner_r, owner_nxt_s;
    logic [IW-1:0]           pick_idx_s;
    logic [IW:0]             rr_sum_s;
    logic                    pick_vld_s;
    logic                    accept_s;
    logic                    last_s;
    logic [NUM_REQ-1:0]      gnt_s;
    logic [CW-1:0]           credit_r;
    logic                    fifo_wr_en_r;
    logic [FIFO_WIDTH-1:0]   fifo_data_r;
    logic                    err_overflow_r;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == LAST_IDX_C) ? {IW{1'b0}} : idx + IW'(1);
    endfunction

    // Candidate selection: owner while locked, else first requester at or after the pointer
    always_comb begin
        pick_vld_s = 1'b0;
        pick_idx_s = '0;
        rr_sum_s   = '0;
        if (state_r == LOCK) begin
            pick_vld_s = req[owner_r];
            pick_idx_s = owner_r;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                rr_sum_s = {1'b0, ptr_r} + (IW+1)'(k);
                rr_sum_s = (rr_sum_s >= NUM_REQ_C) ? rr_sum_s - NUM_REQ_C : rr_sum_s;
                if (!pick_vld_s && req[rr_sum_s[IW-1:0]]) begin
                    pick_vld_s = 1'b1;
                    pick_idx_s = rr_sum_s[IW-1:0];
                end else begin
                    pick_vld_s = pick_vld_s;
                end
            end
        end
    end

    // Grant only with a free slot and outside reset
    always_comb begin
        gnt_s = '0;
        if (rst_n && pick_vld_s && (credit_r != '0)) begin
            gnt_s[pick_idx_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
    end

    assign accept_s = |gnt_s;
    assign last_s   = req_last[pick_idx_s];

    // Next-state, pointer and owner update
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        owner_nxt_s = owner_r;
        case (state_r)
            ARB: begin
                if (accept_s && !last_s) begin
                    state_nxt_s = LOCK;
                    owner_nxt_s = pick_idx_s;
                end else if (accept_s) begin
                    ptr_nxt_s = next_idx(pick_idx_s);
                end else begin
                    state_nxt_s = ARB;
                end
            end
            LOCK: begin
                if (accept_s && last_s) begin
                    state_nxt_s = ARB;
                    ptr_nxt_s   = next_idx(owner_r);
                end else begin
                    state_nxt_s = LOCK;
                end
            end
            default: begin
                state_nxt_s = ARB;
                ptr_nxt_s   = '0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB;
            ptr_r   <= '0;
            owner_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            owner_r <= owner_nxt_s;
        end
    end

    // Registered FIFO write port; data holds when no beat was accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_en_r <= 1'b0;
            fifo_data_r  <= '0;
        end else begin
            fifo_wr_en_r <= accept_s;
            fifo_data_r  <= accept_s ? req_data[pick_idx_s*FIFO_WIDTH +: FIFO_WIDTH] : fifo_data_r;
        end
    end

    // Free-slot tracking; a pop with the FIFO already empty of our writes is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_r <= DEPTH_C;
        end else begin
            case ({accept_s, fifo_rd_pop})
                2'b10:   credit_r <= credit_r - CW'(1);
                2'b01:   credit_r <= (credit_r == DEPTH_C) ? credit_r : credit_r + CW'(1);
                default: credit_r <= credit_r;
            endcase
        end
    end

    // Sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overflow_r <= 1'b0;
        end else begin
            err_overflow_r <= err_overflow_r | fifo_overflow;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_cnt_r;

    // Count cycles where someone requests but nobody is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'h0000;
        end else if ((|req) && (gnt_s == '0) && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 16'h0000;
`endif

    assign gnt          = gnt_s;
    assign fifo_wr_en   = fifo_wr_en_r;
    assign fifo_data_in = fifo_data_r;
    assign credit       = credit_r;
    assign err_overflow = err_overflow_r;

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
Parameters:
REQ-001 NUM_REQ, 4, number of producers, 2..8.
REQ-002 FIFO_WIDTH, 16, data word width.
REQ-003 FIFO_DEPTH, 8, downstream FIFO depth in words, power of two.
Ports:
REQ-004 clk  in  1  single clock, all state on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req  in  NUM_REQ  per-producer word valid.
REQ-007 req_last  in  NUM_REQ  per-producer end-of-packet marker, qualified by req.
REQ-008 req_data  in  NUM_REQ*FIFO_WIDTH  producer i word at bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-009 gnt  out  NUM_REQ  one-hot-or-zero accept; beat transfers when req[i] and gnt[i].
REQ-010 fifo_wr_en  out  1  registered FIFO write strobe.
REQ-011 fifo_data_in  out  FIFO_WIDTH  registered FIFO write data.
REQ-012 fifo_rd_pop  in  1  one word left the FIFO this cycle (rd_en and not empty).
REQ-013 fifo_overflow  in  1  FIFO overflow flag.
REQ-014 credit  out  clog2(FIFO_DEPTH)+1  free FIFO slots as tracked by the arbiter.
REQ-015 err_overflow  out  1  sticky overflow error.
REQ-016 stall_cnt  out  16  arbitration stall counter (see Configuration).

Function
REQ-017 gnt SHALL be combinational from req, state, pointer and credit; at most one bit high.
REQ-018 Grant SHALL require credit > 0; credit == 0 forces gnt = 0.
REQ-019 Accepted beat in cycle t SHALL appear as fifo_wr_en = 1 and fifo_data_in = that word in cycle t+1; otherwise fifo_wr_en = 0 and fifo_data_in holds.
REQ-020 credit next = credit - (beat accepted) + fifo_rd_pop; simultaneous accept and pop leaves credit unchanged.
REQ-021 fifo_rd_pop with credit == FIFO_DEPTH and no accept SHALL be ignored (credit saturates at FIFO_DEPTH).
REQ-022 FSM states ARB and LOCK; ARB: round-robin among req, highest priority = index after last-granted, wrapping NUM_REQ-1 -> 0.
REQ-023 ARB -> LOCK on accepted beat with req_last = 0; owner = granted index.
REQ-024 LOCK: only owner eligible; other requests get no grant even if owner req = 0 (bubble allowed).
REQ-025 LOCK -> ARB on owner beat accepted with req_last = 1; round-robin pointer advances to owner+1.
REQ-026 Single-beat packet (req_last = 1 in ARB) SHALL stay in ARB and advance pointer.
REQ-027 err_overflow SHALL set on any cycle fifo_overflow = 1 and hold until reset.
REQ-028 Arbiter SHALL never issue more than FIFO_DEPTH un-popped writes.

Reset
REQ-029 rst_n low SHALL immediately force: gnt 0, fifo_wr_en 0, fifo_data_in 0, credit = FIFO_DEPTH, err_overflow 0, stall_cnt 0, state ARB, pointer to requester 0.
REQ-030 Reset mid-packet SHALL drop LOCK; a write registered but not yet issued SHALL be discarded.

Configuration
REQ-031 Macro FIFO_WR_ARB_STATS_EN defined: stall_cnt increments each cycle with any req high and gnt == 0, saturating at 16'hFFFF.
REQ-032 Macro undefined: stall_cnt tied to 0, no counter logic.

Verification
REQ-033 req = 4'b1111, all req_last = 1, no pops -> grants 0,1,2,3,0,1,2,3 on consecutive cycles, credit 8 -> 0, then gnt = 0.
REQ-034 credit = 0, req[2] = 1, fifo_rd_pop pulse -> credit 1, gnt[2] next cycle, fifo_wr_en one cycle after, credit back to 0.
REQ-035 Producer 1 sends 3-beat packet while req[0] = 1 -> gnt[1] for all 3 beats, gnt[0] only after beat with req_last, order 1,1,1,0.
REQ-036 Accept and fifo_rd_pop same cycle at credit = 5 -> credit stays 5; pop at credit = 8 alone -> credit stays 8.
REQ-037 rst_n low during LOCK with pending write -> fifo_wr_en 0, credit 8, next grant follows round-robin from requester 0.
REQ-038 fifo_overflow pulsed one cycle -> err_overflow 1 until rst_n; with FIFO_WR_ARB_STATS_EN, 10 stalled cycles -> stall_cnt = 10.
